// File: rtl/tanh_preact_quantizer_4bit.sv
// rtl/tanh_preact_quantizer_4bit.sv - accumulate a vector of signed terms, round-shift and saturate to a 4-bit tanh input code
module tanh_preact_quantizer_4bit #(
    parameter int DW    = 8,
    parameter int LEN   = 16,
    parameter int SHIFT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_code,
    output logic          out_sat,
    output logic [15:0]   sat_count
);
    localparam int CW   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int ACCW = DW + CW;
    // One guard bit so the rounding offset can never wrap the sum.
    localparam int RW   = ACCW + 1;
    localparam logic [CW-1:0]        LAST_IDX = CW'(LEN - 1);
    localparam logic signed [RW-1:0] R_MAX    = RW'(7);
    localparam logic signed [RW-1:0] R_MIN    = -RW'(8);
    localparam logic [RW-1:0]        HALF     = RW'(1) << (SHIFT - 1);

    typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic                    run_q;
    logic [ACCW-1:0]         acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [3:0]              code_q, code_d;
    logic                    sat_q, sat_d;
    logic [15:0]             satcnt_q, satcnt_d;

    logic                    accept;
    logic                    ending;
    logic [ACCW-1:0]         sum;
    logic signed [RW-1:0]    rnd;
    logic signed [RW-1:0]    r;
    logic                    clip_hi;
    logic                    clip_lo;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (ending)    state_d = ST_HOLD;
            ST_HOLD: if (out_ready) state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    // run_q keeps in_ready low on the reset edge and raises it one edge later.
    always_comb begin
        in_ready  = run_q && (state_q == ST_ACC);
        out_valid = (state_q == ST_HOLD);
    end

    assign accept  = in_valid && in_ready;
    assign ending  = accept && (in_last || (cnt_q == LAST_IDX));
    assign sum     = acc_q + {{CW{in_data[DW-1]}}, in_data};
    assign rnd     = {sum[ACCW-1], sum} + HALF;
    assign r       = rnd >>> SHIFT;
    assign clip_hi = (r > R_MAX);
    assign clip_lo = (r < R_MIN);

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        sat_d    = sat_q;
        satcnt_d = satcnt_q;
        if (ending) begin
            acc_d  = '0;
            cnt_d  = '0;
            sat_d  = clip_hi || clip_lo;
            code_d = clip_hi ? 4'b0111 : (clip_lo ? 4'b1000 : r[3:0]);
            if ((clip_hi || clip_lo) && (satcnt_q != 16'hFFFF)) begin
                satcnt_d = satcnt_q + 16'd1;
            end
        end else if (accept) begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            code_q   <= '0;
            sat_q    <= 1'b0;
            satcnt_q <= '0;
        end else begin
            run_q    <= 1'b1;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            sat_q    <= sat_d;
            satcnt_q <= satcnt_d;
        end
    end

    assign out_code  = code_q;
    assign out_sat   = sat_q;
    assign sat_count = satcnt_q;
endmodule

// File: tb/tb_tanh_preact_quantizer_4bit.sv
// tb/tb_tanh_preact_quantizer_4bit.sv - scoreboard bench for tanh_preact_quantizer_4bit
module tb_tanh_preact_quantizer_4bit;
    localparam int DW = 8;
    localparam int LEN = 16;
    localparam int SHIFT = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    out_code;
    logic          out_sat;
    logic [15:0]   sat_count;

    tanh_preact_quantizer_4bit #(.DW(DW), .LEN(LEN), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_sat(out_sat), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        bit sat;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   rand_ready = 0;

    int   acc_m = 0;
    int   len_m = 0;
    int   satcnt_m = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference model: returns 1 when this accepted beat closes the vector.
    function automatic bit model_beat(input int d, input bit last);
        int r;
        exp_t e;
        acc_m += d;
        len_m++;
        if (!(last || len_m == LEN)) return 0;
        r = floor_div(acc_m + (1 << (SHIFT - 1)), 1 << SHIFT);
        e.sat = (r > 7) || (r < -8);
        e.code = (r > 7) ? 7 : (r < -8) ? -8 : r;
        if (e.sat && satcnt_m < 65535) satcnt_m++;
        e.cnt = satcnt_m;
        sb.push_back(e);
        acc_m = 0;
        len_m = 0;
        return 1;
    endfunction

    task automatic beat(input int d, input bit last);
        bit ok;
        bit ends;
        int n;
        in_valid = 1'b1;
        in_data  = DW'(d);
        in_last  = last;
        n = 0;
        ok = 0;
        while (!ok && n < 300) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            n++;
        end
        #1;
        if (!ok) begin
            check("beat_accept_timeout", 0, 1);
        end else begin
            ends = model_beat(d, last);
            if (ends) begin
                check("latency_out_valid", int'(out_valid), 1);
                check("hold_in_ready_low", int'(in_ready), 0);
            end
        end
    endtask

    task automatic vec_const(input int d, input int n, input bit last_at_end);
        for (int i = 0; i < n; i++) beat(d, last_at_end && (i == n - 1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("scoreboard_drained", sb.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pops on each handshake and checks stability while held.
    bit       prev_valid = 0;
    bit       prev_hs = 0;
    bit [3:0] prev_code = '0;
    bit       prev_sat = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            prev_valid = 0;
            prev_hs = 0;
        end else begin
            if (out_valid && prev_valid && !prev_hs) begin
                check("hold_code_stable", int'(out_code), int'(prev_code));
                check("hold_sat_stable", int'(out_sat), int'(prev_sat));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_code", int'($signed(out_code)), e.code);
                    check("out_sat", int'(out_sat), int'(e.sat));
                    check("sat_count", int'(sat_count), e.cnt);
                end
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
            prev_code  = out_code;
            prev_sat   = out_sat;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_code", int'(out_code), 0);
        check("rst_out_sat", int'(out_sat), 0);
        check("rst_sat_count", int'(sat_count), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", int'(in_ready), 1);

        out_ready = 1'b1;
        vec_const(1, 16, 0);
        vec_const(127, 16, 0);
        vec_const(-128, 16, 0);
        beat(8, 0);
        beat(8, 0);
        beat(7, 1);
        in_valid = 1'b0;
        vec_const(-1, 16, 0);
        vec_const(127, 1, 1);
        vec_const(-100, 1, 1);
        drain();

        // Backpressure with live but ignored input traffic.
        out_ready = 1'b0;
        vec_const(5, 3, 1);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = DW'($urandom_range(0, 255));
            in_last = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", int'(out_valid), 0);
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_sb_empty", sb.size(), 0);

        // Reset in the middle of a vector.
        vec_const(50, 5, 0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_sat_count", int'(sat_count), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        sb.delete();
        acc_m = 0;
        len_m = 0;
        satcnt_m = 0;
        reset_n = 1'b1;
        vec_const(2, 16, 0);
        drain();

        // Randomized vectors with random lengths, in_last usage and backpressure.
        rand_ready = 1;
        for (int v = 0; v < 60; v++) begin
            int n;
            bit use_last;
            n = $urandom_range(1, 20);
            use_last = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                int d;
                d = $urandom_range(0, 3) == 0 ? int'($signed(DW'($urandom_range(0, 255))))
                                              : $urandom_range(0, 15) - 8;
                beat(d, use_last && (i == n - 1));
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        // Flush any open vector so every model result gets produced.
        if (len_m != 0) vec_const(0, 1, 1);
        rand_ready = 0;
        #1;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=timeout required=finish");
        $fatal(1, "timeout");
    end
endmodule
